l1_port_arbiter: RTL
====================

Name: l1_port_arbiter

Overview:
- Shares the single CPU-side port of L1_cache between NUM_REQ requesters, e.g. instruction fetch and load/store units.
- Round-robin grant; one transaction outstanding at a time.
- Converts each requester's level request into the one-cycle cpu_read/cpu_write pulse the L1 expects, then tracks cpu_ready to completion.
- Sits between the requesters and L1_cache; L2_cache and memory are unaffected.

Parameters:
- ADDR_WIDTH, 11, address width; matches L1_cache.
- DATA_WIDTH, 8, data word width; matches L1_cache.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request; held high until that requester's done pulse.
- req_write  input  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- req_done  output  NUM_REQ  one-cycle completion pulse, one-hot.
- req_rdata  output  DATA_WIDTH  read data; valid in the req_done cycle.
- cpu_addr  output  ADDR_WIDTH  to L1.
- cpu_data_in  output  DATA_WIDTH  to L1.
- cpu_read  output  1  to L1.
- cpu_write  output  1  to L1.
- cpu_data_out  input  DATA_WIDTH  from L1.
- cpu_ready  input  1  from L1.
- timeout_err  output  1  sticky watchdog flag; exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; watchdog counter 0. Asynchronous reset mid-transaction aborts it with no done pulse; requesters re-present after reset.
- IDLE:
  - If any req_valid is high, grant the first set bit searching circularly from rr_ptr.
  - Register the grant index, addr, wdata and write flag into the held command registers.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive cpu_addr and cpu_data_in from the held command registers.
  - Drive cpu_write = held write flag, cpu_read = its inverse.
  - Go to ACK.
- ACK:
  - cpu_read/cpu_write are 0; cpu_addr is held stable.
  - Wait for cpu_ready == 0, then go to BUSY.
  - If cpu_ready is 1 in the 2nd cycle of ACK, treat it as a same-cycle completion and go to DONE.
- BUSY: wait for cpu_ready == 1, then go to DONE.
- DONE (1 cycle):
  - req_done[grant] = 1; req_rdata = cpu_data_out sampled on cpu_ready rise. Writes return req_rdata = 0.
  - rr_ptr = (grant + 1) mod NUM_REQ.
  - Go to IDLE. Minimum gap between grants is 1 IDLE cycle.
- Latency: request to cpu_read pulse = 2 cycles from req_valid rise while idle. Request to done = L1 latency + 3.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 other transactions.
- Request changes while a transaction is in flight are ignored; the held command registers are authoritative.
- A requester that drops req_valid before its done pulse still has its transaction completed. Its done pulse is still issued; the requester must ignore it.
- Simultaneous requests in IDLE: rr_ptr decides. After reset, requester 0 wins.
- rr_ptr wraps from NUM_REQ-1 to 0.
- cpu_read and cpu_write are never both 1.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in ACK and BUSY.
  - On reaching TIMEOUT_CYCLES: set timeout_err (sticky until reset), pulse req_done[grant] with req_rdata = 0, return to IDLE.
- ARB_TIMEOUT_EN undefined: no counter and no timeout_err port; the arbiter waits indefinitely.

Decomposition:
- Shared package cache_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, ACK, BUSY, DONE};
  - default ADDR_WIDTH and DATA_WIDTH constants.
- One sub-module: rr_picker. Combinational, taking req vector and rr_ptr and returning grant index plus any_req. It is reused later for the L2 port.

Test Plan:
- Single read: req_valid=01, addr0=0x123 -> cpu_read pulses for 1 cycle with cpu_addr=0x123; req_done=01 with req_rdata = L1 data; no other pulses.
- Contention: both requesters held high for 4 transactions from reset -> grants in order 0,1,0,1; each done pulse is one-hot; cpu_read/cpu_write never both 1.
- Write then read: requester1 writes 0xA5 @0x040, then requester0 reads 0x040 -> cpu_write pulse carries 0xA5; the read returns req_rdata=0xA5.
- Stability: change req_addr while in BUSY -> cpu_addr keeps the latched value until DONE.
- Reset mid-transaction: assert rst_n=0 during BUSY -> outputs 0 immediately; no req_done; after release, requester 0 is granted first.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, L1 stub holds cpu_ready low -> after 16 cycles timeout_err=1, req_done pulses with rdata 0, arbiter returns to IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the cache-side port arbiters (L1 now, L2 later).
//   - arb_state_t    : arbiter transaction state encoding
//   - DEF_ADDR_WIDTH : default CPU-side address width (matches L1_cache)
//   - DEF_DATA_WIDTH : default CPU-side data width (matches L1_cache)
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ACK   = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/l1_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Returns the index of the first set
//   bit of req, searching circularly upward starting at rr_ptr.
//   Ports:
//     req     in  NUM_REQ    request vector
//     rr_ptr  in  IDX_WIDTH  highest-priority index for this pick
//     grant   out IDX_WIDTH  selected index (0 when no request)
//     any_req out 1          at least one request bit is set
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] grant,
  output logic                 any_req
);

  int idx;

  // Walk offsets from farthest to nearest so the bit closest to rr_ptr is
  // written last and therefore wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      grant = req[idx] ? IDX_WIDTH'(idx) : grant;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/l1_port_arbiter.sv
// ---------------------------------------------------------------------------
// l1_port_arbiter
//   Shares the single CPU-side port of L1_cache between NUM_REQ requesters.
//   Round-robin grant, one transaction in flight. A level request is turned
//   into a single-cycle cpu_read/cpu_write pulse, then cpu_ready is tracked
//   (drop then rise, or still high in the second ACK cycle for a same-cycle
//   hit) until completion, which is reported by a one-hot req_done pulse.
//
//   Optional build macro ARB_TIMEOUT_EN adds a watchdog and the sticky
//   timeout_err output; without it the arbiter waits on the L1 indefinitely.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid[N]        level request, held until its req_done
//     req_write[N]        1 = write, 0 = read
//     req_addr[N*AW]      packed addresses (slice i = requester i)
//     req_wdata[N*DW]     packed write data
//     req_done[N]         one-cycle one-hot completion pulse
//     req_rdata[DW]       read data, valid with req_done (0 for writes)
//     cpu_addr/cpu_data_in/cpu_read/cpu_write   command to L1
//     cpu_data_out/cpu_ready                    response from L1
//     timeout_err         sticky watchdog flag (ARB_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module l1_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [ADDR_WIDTH-1:0]         cpu_addr,
  output logic [DATA_WIDTH-1:0]         cpu_data_in,
  output logic                          cpu_read,
  output logic                          cpu_write,
  input  logic [DATA_WIDTH-1:0]         cpu_data_out,
  input  logic                          cpu_ready
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations the round-robin pointer and watchdog do not cover.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("l1_port_arbiter: unsupported parameter set");
  end

  arb_state_t state_r;
  arb_state_t state_next_s;

  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         grant_r;
  logic [IW-1:0]         pick_s;
  logic                  any_req_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  logic [DATA_WIDTH-1:0] cmd_wdata_r;
  logic                  cmd_write_r;
  logic                  ack_second_r;
  logic                  timeout_hit_s;
  logic [ADDR_WIDTH-1:0] pick_addr_s;
  logic [DATA_WIDTH-1:0] pick_wdata_s;
  logic                  pick_write_s;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IW)
  ) u_rr_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_r),
    .grant   (pick_s),
    .any_req (any_req_s)
  );

  assign pick_addr_s  = req_addr[int'(pick_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_wdata_s = req_wdata[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
  assign pick_write_s = req_write[pick_s];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. In ACK the first cycle only reacts to an early ready
  // drop; a ready still high in the second cycle means the L1 already
  // finished (hit) and we complete without passing through BUSY.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = ACK;
      end
      ACK: begin
        if (timeout_hit_s) begin
          state_next_s = DONE;
        end else if (!cpu_ready) begin
          state_next_s = BUSY;
        end else if (ack_second_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACK;
        end
      end
      BUSY: begin
        if (timeout_hit_s || cpu_ready) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Command capture, registered L1 command outputs and completion outputs.
  // Outputs are loaded on the edge that enters the state they belong to, so
  // the cpu pulse is visible one cycle after ISSUE and req_done during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      cmd_addr_r   <= '0;
      cmd_wdata_r  <= '0;
      cmd_write_r  <= 1'b0;
      ack_second_r <= 1'b0;
      cpu_addr     <= '0;
      cpu_data_in  <= '0;
      cpu_read     <= 1'b0;
      cpu_write    <= 1'b0;
      req_done     <= '0;
      req_rdata    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r     <= pick_s;
            cmd_addr_r  <= pick_addr_s;
            cmd_wdata_r <= pick_wdata_s;
            cmd_write_r <= pick_write_s;
          end else begin
            grant_r     <= grant_r;
          end
        end
        ISSUE: begin
          cpu_addr     <= cmd_addr_r;
          cpu_data_in  <= cmd_wdata_r;
          cpu_write    <= cmd_write_r;
          cpu_read     <= ~cmd_write_r;
          ack_second_r <= 1'b0;
        end
        ACK, BUSY: begin
          cpu_read     <= 1'b0;
          cpu_write    <= 1'b0;
          ack_second_r <= 1'b1;
          if (state_next_s == DONE) begin
            req_done <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
            // Writes and watchdog aborts carry no data back.
            if (cmd_write_r || timeout_hit_s) begin
              req_rdata <= '0;
            end else begin
              req_rdata <= cpu_data_out;
            end
          end else begin
            req_done <= '0;
          end
        end
        DONE: begin
          req_done     <= '0;
          req_rdata    <= '0;
          ack_second_r <= 1'b0;
          if (grant_r == IW'(NUM_REQ - 1)) begin
            rr_ptr_r <= '0;
          end else begin
            rr_ptr_r <= grant_r + IW'(1);
          end
        end
        default: begin
          cpu_read  <= 1'b0;
          cpu_write <= 1'b0;
          req_done  <= '0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt_r;

  // Watchdog: counts cycles spent waiting on the L1 for the current command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= '0;
    end else if (state_r == ACK || state_r == BUSY) begin
      wd_cnt_r <= wd_cnt_r + TW'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th waiting cycle.
  assign timeout_hit_s = ((state_r == ACK) || (state_r == BUSY)) &&
                         (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err <= 1'b1;
    end else begin
      timeout_err <= timeout_err;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

endmodule
